// File: rtl/uart_status_tx_if.sv
// Write port towards the simpleuart data register: strobe and data go out,
// the busy/wait indication comes back.
interface uart_status_tx_if;
    logic        reg_dat_we;
    logic [31:0] reg_dat_di;
    logic        reg_dat_wait;

    modport master (
        output reg_dat_we,
        output reg_dat_di,
        input  reg_dat_wait
    );

    modport slave (
        input  reg_dat_we,
        input  reg_dat_di,
        output reg_dat_wait
    );
endinterface

// File: rtl/uart_status_tx.sv
// Status reporter: on a trigger or periodic tick, writes a 9-byte ASCII frame
// "S<r><g><b> <hex hi><hex lo>\r\n" into the simpleuart data register.
module uart_status_tx #(
    parameter int unsigned AUTO_PERIOD = 32'd12000000
) (
    input  logic                    hw_clk,
    input  logic                    reset,
    input  logic                    trigger,
    input  logic [2:0]              rgb,
    input  logic [7:0]              rx_count,
    uart_status_tx_if.master        dat,
    output logic                    busy,
    output logic                    done
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam bit          AUTO_EN   = (AUTO_PERIOD != 32'd0);
    localparam logic [31:0] PERIOD_M1 = AUTO_PERIOD - 32'd1;

    state_e      state_q;
    logic [3:0]  idx_q;
    logic        we_q;
    logic [7:0]  di_q;
    logic        busy_q;
    logic        done_q;
    logic        pending_q;
    logic [2:0]  snap_rgb_q;
    logic [7:0]  snap_cnt_q;
    logic [31:0] tick_cnt_q;
    logic [31:0] tick_cnt_d;

    logic        tick_s;
    logic        req_s;
    logic        start_s;
    logic        accept_s;

    function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
        if (nib < 4'd10) begin
            hex_ascii = 8'h30 + {4'h0, nib};
        end else begin
            hex_ascii = 8'h37 + {4'h0, nib};
        end
    endfunction

    function automatic logic [7:0] frame_byte(input logic [3:0] idx,
                                              input logic [2:0] led,
                                              input logic [7:0] cnt);
        case (idx)
            4'd0:    frame_byte = 8'h53;
            4'd1:    frame_byte = {7'h18, led[2]};
            4'd2:    frame_byte = {7'h18, led[1]};
            4'd3:    frame_byte = {7'h18, led[0]};
            4'd4:    frame_byte = 8'h20;
            4'd5:    frame_byte = hex_ascii(cnt[7:4]);
            4'd6:    frame_byte = hex_ascii(cnt[3:0]);
            4'd7:    frame_byte = 8'h0D;
            4'd8:    frame_byte = 8'h0A;
            default: frame_byte = 8'h00;
        endcase
    endfunction

    // Free-running report period counter; tick fires on the wrap cycle.
    always_comb begin
        tick_cnt_d = tick_cnt_q;
        tick_s     = 1'b0;
        if (!AUTO_EN) begin
            tick_cnt_d = 32'd0;
        end else if (tick_cnt_q == PERIOD_M1) begin
            tick_cnt_d = 32'd0;
            tick_s     = 1'b1;
        end else begin
            tick_cnt_d = tick_cnt_q + 32'd1;
        end
    end

    // Frame start decision and write acceptance.
    always_comb begin
        req_s    = trigger | tick_s;
        accept_s = we_q & ~dat.reg_dat_wait;
        case (state_q)
            ST_IDLE: start_s = req_s;
            ST_DONE: start_s = req_s | pending_q;
            default: start_s = 1'b0;
        endcase
    end

    // Period counter register.
    always_ff @(posedge hw_clk) begin
        if (reset) begin
            tick_cnt_q <= 32'd0;
        end else begin
            tick_cnt_q <= tick_cnt_d;
        end
    end

    // Frame sequencer with registered write port and status outputs.
    always_ff @(posedge hw_clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            idx_q      <= 4'd0;
            we_q       <= 1'b0;
            di_q       <= 8'h00;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pending_q  <= 1'b0;
            snap_rgb_q <= 3'b000;
            snap_cnt_q <= 8'h00;
        end else begin
            done_q <= 1'b0;
            if (start_s) begin
                // Byte 0 is a constant, so the fresh snapshot is not needed yet.
                state_q    <= ST_SEND;
                snap_rgb_q <= rgb;
                snap_cnt_q <= rx_count;
                idx_q      <= 4'd0;
                we_q       <= 1'b1;
                di_q       <= frame_byte(4'd0, rgb, rx_count);
                busy_q     <= 1'b1;
                pending_q  <= 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        state_q <= ST_IDLE;
                    end
                    ST_SEND: begin
                        if (req_s) begin
                            pending_q <= 1'b1;
                        end
                        if (accept_s) begin
                            if (idx_q == 4'd8) begin
                                state_q <= ST_DONE;
                                idx_q   <= 4'd0;
                                we_q    <= 1'b0;
                                di_q    <= 8'h00;
                                busy_q  <= 1'b0;
                                done_q  <= 1'b1;
                            end else begin
                                idx_q <= idx_q + 4'd1;
                                di_q  <= frame_byte(idx_q + 4'd1, snap_rgb_q, snap_cnt_q);
                            end
                        end
                    end
                    ST_DONE: begin
                        state_q <= ST_IDLE;
                    end
                    default: begin
                        state_q   <= ST_IDLE;
                        idx_q     <= 4'd0;
                        we_q      <= 1'b0;
                        di_q      <= 8'h00;
                        busy_q    <= 1'b0;
                        pending_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign dat.reg_dat_we = we_q;
    assign dat.reg_dat_di = {24'h000000, di_q};
    assign busy           = busy_q;
    assign done           = done_q;

endmodule

// File: tb/tb_uart_status_tx.sv
// Bench for uart_status_tx: expected frame bytes are queued when a report is
// requested and matched against the writes the simpleuart side accepts.
module tb_uart_status_tx;

    logic       hw_clk = 1'b0;
    logic       reset;
    logic       trigger;
    logic [2:0] rgb;
    logic [7:0] rx_count;
    logic       busy;
    logic       done;
    logic       reset100;
    logic       trig100;
    logic       busy100;
    logic       done100;

    always #5 hw_clk = ~hw_clk;

    uart_status_tx_if bus();
    uart_status_tx_if bus100();

    uart_status_tx #(.AUTO_PERIOD(0)) dut (
        .hw_clk   (hw_clk),
        .reset    (reset),
        .trigger  (trigger),
        .rgb      (rgb),
        .rx_count (rx_count),
        .dat      (bus),
        .busy     (busy),
        .done     (done)
    );

    uart_status_tx #(.AUTO_PERIOD(100)) dut100 (
        .hw_clk   (hw_clk),
        .reset    (reset100),
        .trigger  (trig100),
        .rgb      (rgb),
        .rx_count (rx_count),
        .dat      (bus100),
        .busy     (busy100),
        .done     (done100)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    byte unsigned exp_q[$];
    byte unsigned got_v[$];
    int           got_c[$];
    int           done_c[$];
    int           auto_c[$];
    int           auto_done_c[$];

    always @(posedge hw_clk) cyc <= cyc + 1;

    // Capture accepted writes and done pulses with the edge index they occur on.
    always @(posedge hw_clk) begin
        if (bus.reg_dat_we === 1'b1 && bus.reg_dat_wait === 1'b0) begin
            got_v.push_back(bus.reg_dat_di[7:0]);
            got_c.push_back(cyc);
        end
        if (done === 1'b1) done_c.push_back(cyc);
        if (bus100.reg_dat_we === 1'b1 && bus100.reg_dat_wait === 1'b0 &&
            bus100.reg_dat_di === 32'h00000053 && busy100 === 1'b1)
            auto_c.push_back(cyc);
        if (done100 === 1'b1) auto_done_c.push_back(cyc);
    end

    function automatic byte unsigned hexc(input logic [3:0] v);
        int x;
        x = v;
        if (x < 10) return byte'(48 + x);
        return byte'(65 + x - 10);
    endfunction

    task automatic push_frame(input logic [2:0] c, input logic [7:0] n);
        exp_q.push_back(8'h53);
        exp_q.push_back(c[2] ? 8'h31 : 8'h30);
        exp_q.push_back(c[1] ? 8'h31 : 8'h30);
        exp_q.push_back(c[0] ? 8'h31 : 8'h30);
        exp_q.push_back(8'h20);
        exp_q.push_back(hexc(n[7:4]));
        exp_q.push_back(hexc(n[3:0]));
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
    endtask

    task automatic clear_mon();
        got_v.delete();
        got_c.delete();
        done_c.delete();
        exp_q.delete();
    endtask

    task automatic pulse_trigger(output int s);
        trigger = 1'b1;
        s = cyc;
        @(negedge hw_clk);
        trigger = 1'b0;
    endtask

    task automatic wait_got(input int n, input int budget, output bit ok);
        for (int i = 0; i < budget; i++) begin
            if (got_v.size() >= n) break;
            @(negedge hw_clk);
        end
        ok = (got_v.size() >= n);
    endtask

    task automatic test_reset();
        bit ok;
        reset = 1'b1;
        reset100 = 1'b1;
        trigger = 1'b1;
        trig100 = 1'b0;
        rgb = 3'b000;
        rx_count = 8'h00;
        bus.reg_dat_wait = 1'b0;
        bus100.reg_dat_wait = 1'b0;
        repeat (3) @(negedge hw_clk);
        n_tests++; if (bus.reg_dat_we !== 1'b0) begin n_fail++; $display("FAIL reset_we: got %b want 0", bus.reg_dat_we); end
        n_tests++; if (bus.reg_dat_di !== 32'h0) begin n_fail++; $display("FAIL reset_di: got %h want 0", bus.reg_dat_di); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
        reset = 1'b0;
        reset100 = 1'b0;
        trigger = 1'b0;
        clear_mon();
        repeat (20) @(negedge hw_clk);
        ok = (got_v.size() == 0);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL reset_trigger_ignored: got %0d bytes want 0", got_v.size()); end
    endtask

    task automatic test_basic();
        int s;
        bit ok;
        byte unsigned e;
        clear_mon();
        rgb = 3'b101;
        rx_count = 8'h3A;
        push_frame(rgb, rx_count);
        pulse_trigger(s);
        n_tests++; if (bus.reg_dat_we !== 1'b1) begin n_fail++; $display("FAIL basic_first_we: got %b want 1", bus.reg_dat_we); end
        n_tests++; if (bus.reg_dat_di !== 32'h00000053) begin n_fail++; $display("FAIL basic_first_di: got %h want 00000053", bus.reg_dat_di); end
        n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy: got %b want 1", busy); end
        wait_got(9, 40, ok);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL basic_timeout: got %0d bytes want 9", got_v.size()); end
        for (int i = 0; i < 9 && i < got_v.size(); i++) begin
            e = exp_q.pop_front();
            n_tests++; if (got_v[i] !== e) begin n_fail++; $display("FAIL basic_byte%0d: got %h want %h", i, got_v[i], e); end
            n_tests++; if (got_c[i] !== s + 1 + i) begin n_fail++; $display("FAIL basic_edge%0d: got %0d want %0d", i, got_c[i], s + 1 + i); end
        end
        repeat (3) @(negedge hw_clk);
        n_tests++; if (done_c.size() != 1 || done_c[0] != s + 10) begin n_fail++; $display("FAIL basic_done: got %0d pulses first at %0d want 1 at %0d", done_c.size(), (done_c.size() > 0) ? done_c[0] : -1, s + 10); end
        n_tests++; if (busy !== 1'b0 || bus.reg_dat_we !== 1'b0) begin n_fail++; $display("FAIL basic_idle: got busy %b we %b want 0 0", busy, bus.reg_dat_we); end
    endtask

    task automatic test_wait_stall();
        int s;
        int hold;
        int k;
        byte unsigned e;
        clear_mon();
        rgb = 3'b101;
        rx_count = 8'h3A;
        push_frame(rgb, rx_count);
        pulse_trigger(s);
        hold = 0;
        for (int c = 0; c < 300 && got_v.size() < 9; c++) begin
            if (bus.reg_dat_we === 1'b1) begin
                k = got_v.size();
                if (k < 9) begin
                    n_tests++; if (bus.reg_dat_di !== {24'h0, exp_q[k]}) begin n_fail++; $display("FAIL stall_hold%0d: got %h want %h", k, bus.reg_dat_di, exp_q[k]); end
                end
                if (hold < 10) begin bus.reg_dat_wait = 1'b1; hold++; end
                else begin bus.reg_dat_wait = 1'b0; hold = 0; end
            end else begin
                bus.reg_dat_wait = 1'b0;
            end
            @(negedge hw_clk);
        end
        bus.reg_dat_wait = 1'b0;
        n_tests++; if (got_v.size() != 9) begin n_fail++; $display("FAIL stall_count: got %0d want 9", got_v.size()); end
        for (int i = 0; i < 9 && i < got_v.size(); i++) begin
            e = exp_q.pop_front();
            n_tests++; if (got_v[i] !== e) begin n_fail++; $display("FAIL stall_byte%0d: got %h want %h", i, got_v[i], e); end
        end
        repeat (3) @(negedge hw_clk);
    endtask

    task automatic test_snapshot();
        int s;
        bit ok;
        byte unsigned e;
        clear_mon();
        rgb = 3'b101;
        rx_count = 8'h3A;
        push_frame(rgb, rx_count);
        pulse_trigger(s);
        repeat (3) @(negedge hw_clk);
        rgb = 3'b010;
        rx_count = 8'hFF;
        wait_got(9, 40, ok);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL snap_timeout: got %0d bytes want 9", got_v.size()); end
        for (int i = 0; i < 9 && i < got_v.size(); i++) begin
            e = exp_q.pop_front();
            n_tests++; if (got_v[i] !== e) begin n_fail++; $display("FAIL snap_old_byte%0d: got %h want %h", i, got_v[i], e); end
        end
        repeat (3) @(negedge hw_clk);
        clear_mon();
        push_frame(rgb, rx_count);
        pulse_trigger(s);
        wait_got(9, 40, ok);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL snap_new_timeout: got %0d bytes want 9", got_v.size()); end
        for (int i = 0; i < 9 && i < got_v.size(); i++) begin
            e = exp_q.pop_front();
            n_tests++; if (got_v[i] !== e) begin n_fail++; $display("FAIL snap_new_byte%0d: got %h want %h", i, got_v[i], e); end
        end
        repeat (3) @(negedge hw_clk);
    endtask

    task automatic test_pending();
        int s;
        bit ok;
        byte unsigned e;
        clear_mon();
        rgb = 3'b101;
        rx_count = 8'h3A;
        push_frame(rgb, rx_count);
        pulse_trigger(s);
        rgb = 3'b011;
        rx_count = 8'h5C;
        push_frame(rgb, rx_count);
        for (int j = 0; j < 3; j++) begin
            @(negedge hw_clk);
            trigger = 1'b1;
            @(negedge hw_clk);
            trigger = 1'b0;
        end
        wait_got(18, 80, ok);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL pend_timeout: got %0d bytes want 18", got_v.size()); end
        for (int i = 0; i < 18 && i < got_v.size(); i++) begin
            e = exp_q.pop_front();
            n_tests++; if (got_v[i] !== e) begin n_fail++; $display("FAIL pend_byte%0d: got %h want %h", i, got_v[i], e); end
        end
        n_tests++; if (got_c.size() < 10 || got_c[9] != s + 11) begin n_fail++; $display("FAIL pend_restart_edge: got %0d want %0d", (got_c.size() > 9) ? got_c[9] : -1, s + 11); end
        repeat (25) @(negedge hw_clk);
        n_tests++; if (got_v.size() != 18) begin n_fail++; $display("FAIL pend_single_extra: got %0d bytes want 18", got_v.size()); end
        n_tests++; if (done_c.size() != 2 || done_c[1] != s + 20) begin n_fail++; $display("FAIL pend_done: got %0d pulses want 2 with last at %0d", done_c.size(), s + 20); end
    endtask

    task automatic test_reset_mid();
        int s;
        bit ok;
        byte unsigned e;
        clear_mon();
        rgb = 3'b101;
        rx_count = 8'h3A;
        push_frame(rgb, rx_count);
        pulse_trigger(s);
        wait_got(5, 40, ok);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL rmid_timeout: got %0d bytes want 5", got_v.size()); end
        reset = 1'b1;
        bus.reg_dat_wait = 1'b1;
        @(negedge hw_clk);
        n_tests++; if (bus.reg_dat_we !== 1'b0) begin n_fail++; $display("FAIL rmid_we: got %b want 0", bus.reg_dat_we); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rmid_busy: got %b want 0", busy); end
        n_tests++; if (bus.reg_dat_di !== 32'h0) begin n_fail++; $display("FAIL rmid_di: got %h want 0", bus.reg_dat_di); end
        reset = 1'b0;
        bus.reg_dat_wait = 1'b0;
        repeat (30) @(negedge hw_clk);
        n_tests++; if (got_v.size() != 5) begin n_fail++; $display("FAIL rmid_no_resume: got %0d bytes want 5", got_v.size()); end
        for (int i = 0; i < 5 && i < got_v.size(); i++) begin
            e = exp_q.pop_front();
            n_tests++; if (got_v[i] !== e) begin n_fail++; $display("FAIL rmid_part_byte%0d: got %h want %h", i, got_v[i], e); end
        end
        clear_mon();
        push_frame(rgb, rx_count);
        pulse_trigger(s);
        wait_got(9, 40, ok);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL rmid_new_timeout: got %0d bytes want 9", got_v.size()); end
        for (int i = 0; i < 9 && i < got_v.size(); i++) begin
            e = exp_q.pop_front();
            n_tests++; if (got_v[i] !== e) begin n_fail++; $display("FAIL rmid_new_byte%0d: got %h want %h", i, got_v[i], e); end
        end
        repeat (3) @(negedge hw_clk);
    endtask

    task automatic test_no_auto();
        clear_mon();
        repeat (300) @(negedge hw_clk);
        n_tests++; if (got_v.size() != 0 || done_c.size() != 0) begin n_fail++; $display("FAIL noauto: got %0d bytes %0d done want 0 0", got_v.size(), done_c.size()); end
    endtask

    task automatic test_auto();
        n_tests++; if (auto_c.size() < 3) begin n_fail++; $display("FAIL auto_count: got %0d frames want at least 3", auto_c.size()); end
        for (int i = 1; i < auto_c.size(); i++) begin
            n_tests++; if (auto_c[i] - auto_c[i-1] != 100) begin n_fail++; $display("FAIL auto_period%0d: got %0d want 100", i, auto_c[i] - auto_c[i-1]); end
        end
        for (int i = 0; i < auto_c.size() && i < auto_done_c.size(); i++) begin
            n_tests++; if (auto_done_c[i] != auto_c[i] + 9) begin n_fail++; $display("FAIL auto_done%0d: got %0d want %0d", i, auto_done_c[i], auto_c[i] + 9); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wait_stall();
        test_snapshot();
        test_pending();
        test_reset_mid();
        test_no_auto();
        test_auto();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_status_tx.md
UART_STATUS_TX -- requirements
Module: uart_status_tx

Interface
REQ-001 Parameter AUTO_PERIOD, default 12000000, hw_clk cycles between automatic reports; 0 disables automatic reports.
REQ-002 hw_clk  input  1  sole clock; all logic on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 trigger  input  1  one-cycle request to send one status frame.
REQ-005 rgb  input  3  current LED state, bit2=red, bit1=green, bit0=blue.
REQ-006 rx_count  input  8  received-byte counter to report.
REQ-007 reg_dat_we  output  1  write strobe to simpleuart data register.
REQ-008 reg_dat_di  output  32  write data to simpleuart; bits 31:8 always 0.
REQ-009 reg_dat_wait  input  1  simpleuart busy; a write is accepted on an edge where reg_dat_we=1 and reg_dat_wait=0.
REQ-010 busy  output  1  high from frame start until the last byte is accepted.
REQ-011 done  output  1  one-cycle pulse after the last byte of a frame is accepted.

Function
REQ-012 Frame is exactly 9 bytes, in order: 0x53 'S'; red, green, blue each as 0x30/0x31; 0x20; rx_count high nibble, low nibble as uppercase ASCII hex (0x30-0x39, 0x41-0x46); 0x0D; 0x0A.
REQ-013 rgb and rx_count are sampled into a snapshot on the edge a frame starts; input changes during a frame do not alter it.
REQ-014 States: IDLE, SEND, DONE; IDLE->SEND on start, SEND->DONE when byte 8 is accepted, DONE->IDLE (or SEND if pending) after one cycle.
REQ-015 Start event: trigger=1 or auto-tick while IDLE; reg_dat_we=1 with byte 0 on reg_dat_di on the cycle after the start edge.
REQ-016 In SEND, reg_dat_we stays 1 continuously and reg_dat_di holds the current byte until accepted; on the accepting edge reg_dat_di advances to the next byte in the same edge.
REQ-017 On acceptance of byte 8, reg_dat_we=0 and done=1 on the next cycle; done is 0 at all other times.
REQ-018 While reg_dat_wait=1, byte index, reg_dat_di and reg_dat_we hold unchanged, with no timeout.
REQ-019 Auto-tick counter counts hw_clk cycles 0..AUTO_PERIOD-1 and wraps; tick occurs on wrap; counter runs regardless of state.
REQ-020 Trigger or tick while busy sets a single pending flag; additional requests while pending are dropped; pending starts a new frame from DONE with a fresh snapshot.
REQ-021 Trigger and tick on the same edge produce one frame only.
REQ-022 Byte index is 4 bits, range 0..8; never exceeds 8.

Reset
REQ-023 On reset=1 at an edge: state IDLE, reg_dat_we=0, reg_dat_di=0, busy=0, done=0, pending=0, byte index=0, auto counter=0, snapshot=0.
REQ-024 Reset mid-frame aborts it: reg_dat_we=0 on the cycle after the reset edge; no partial frame resumes after release.
REQ-025 trigger asserted in the same cycle as reset is ignored.

Verification
REQ-026 rgb=3'b101, rx_count=0x3A, wait=0, trigger pulse -> bytes 53 31 30 31 20 33 41 0D 0A accepted on 9 consecutive edges starting the cycle after trigger; done one cycle later.
REQ-027 Model simpleuart wait high for 10 cycles per byte -> each byte held stable on reg_dat_di with reg_dat_we=1 until accepted; frame content unchanged.
REQ-028 Change rgb to 3'b010 and rx_count to 0xFF mid-frame -> frame still reports 101/3A; next trigger reports 30 31 30 and 46 46.
REQ-029 Three triggers during one frame -> exactly one extra frame, starting the cycle after done.
REQ-030 AUTO_PERIOD=100, no trigger -> frame start every 100 cycles; AUTO_PERIOD=0 -> no frame ever without trigger.
REQ-031 Reset asserted after byte 4 accepted -> reg_dat_we=0 next cycle, busy=0, no further bytes until a new trigger, which begins at 0x53.
